// File: rtl/ins_encode_if.sv
// Request/response bundle of the instruction encoder: an instruction-field
// request channel in, an encoded-word channel out, plus the transfer counter.
interface ins_encode_if;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_inscode;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [4:0]  in_shamt;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic        out_illegal;
  logic [15:0] enc_count;

  modport master (
    output in_valid, in_inscode, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target, out_ready,
    input  in_ready, out_valid, out_word, out_illegal, enc_count
  );

  modport slave (
    input  in_valid, in_inscode, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target, out_ready,
    output in_ready, out_valid, out_word, out_illegal, enc_count
  );
endinterface

// File: rtl/ins_encode.sv
// Encodes internal instruction codes into MIPS32 words and buffers them in a
// two-entry FIFO with a registered in_ready and a completed-transfer counter.
module ins_encode (
  input logic         clk,
  input logic         rst,
  ins_encode_if.slave bus
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  typedef enum logic [3:0] {
    FMT_NOP, FMT_R, FMT_I, FMT_REGIMM, FMT_J, FMT_ERET, FMT_MFC0, FMT_MTC0, FMT_ILL
  } fmt_t;

  fmt_t        fmt;
  logic [5:0]  sel;
  logic [31:0] encWord;
  logic        encIllegal;

  state_t      state_q, state_d;
  logic [31:0] headWord_q, headWord_d, tailWord_q, tailWord_d;
  logic        headIll_q, headIll_d, tailIll_q, tailIll_d;
  logic        inReady_q;
  logic [15:0] encCount_q, encCount_d;
  logic        push, pop;

  // sel carries the R-type funct, I/J-type opcode or REGIMM rt selector
  always_comb begin
    fmt = FMT_ILL;
    sel = 6'h00;
    case (bus.in_inscode)
      6'd0:  fmt = FMT_NOP;
      6'd1:  begin fmt = FMT_R; sel = 6'h20; end
      6'd2:  begin fmt = FMT_I; sel = 6'h08; end
      6'd3:  begin fmt = FMT_R; sel = 6'h21; end
      6'd4:  begin fmt = FMT_I; sel = 6'h09; end
      6'd5:  begin fmt = FMT_R; sel = 6'h22; end
      6'd6:  begin fmt = FMT_R; sel = 6'h23; end
      6'd7:  begin fmt = FMT_R; sel = 6'h2A; end
      6'd8:  begin fmt = FMT_I; sel = 6'h0A; end
      6'd9:  begin fmt = FMT_R; sel = 6'h2B; end
      6'd10: begin fmt = FMT_I; sel = 6'h0B; end
      6'd11: begin fmt = FMT_R; sel = 6'h1A; end
      6'd12: begin fmt = FMT_R; sel = 6'h1B; end
      6'd13: begin fmt = FMT_R; sel = 6'h18; end
      6'd14: begin fmt = FMT_R; sel = 6'h19; end
      6'd15: begin fmt = FMT_R; sel = 6'h24; end
      6'd16: begin fmt = FMT_I; sel = 6'h0C; end
      6'd17: begin fmt = FMT_I; sel = 6'h0F; end
      6'd18: begin fmt = FMT_R; sel = 6'h27; end
      6'd19: begin fmt = FMT_R; sel = 6'h25; end
      6'd20: begin fmt = FMT_I; sel = 6'h0D; end
      6'd21: begin fmt = FMT_R; sel = 6'h26; end
      6'd22: begin fmt = FMT_I; sel = 6'h0E; end
      6'd23: begin fmt = FMT_R; sel = 6'h00; end
      6'd24: begin fmt = FMT_R; sel = 6'h04; end
      6'd25: begin fmt = FMT_R; sel = 6'h03; end
      6'd26: begin fmt = FMT_R; sel = 6'h07; end
      6'd27: begin fmt = FMT_R; sel = 6'h02; end
      6'd28: begin fmt = FMT_R; sel = 6'h06; end
      6'd29: begin fmt = FMT_I; sel = 6'h04; end
      6'd30: begin fmt = FMT_I; sel = 6'h05; end
      6'd31: begin fmt = FMT_REGIMM; sel = 6'h01; end
      6'd32: begin fmt = FMT_I; sel = 6'h07; end
      6'd33: begin fmt = FMT_I; sel = 6'h06; end
      6'd34: begin fmt = FMT_REGIMM; sel = 6'h00; end
      6'd35: begin fmt = FMT_REGIMM; sel = 6'h10; end
      6'd36: begin fmt = FMT_REGIMM; sel = 6'h11; end
      6'd37: begin fmt = FMT_J; sel = 6'h02; end
      6'd38: begin fmt = FMT_J; sel = 6'h03; end
      6'd39: begin fmt = FMT_R; sel = 6'h08; end
      6'd40: begin fmt = FMT_R; sel = 6'h09; end
      6'd41: begin fmt = FMT_R; sel = 6'h10; end
      6'd42: begin fmt = FMT_R; sel = 6'h12; end
      6'd43: begin fmt = FMT_R; sel = 6'h11; end
      6'd44: begin fmt = FMT_R; sel = 6'h13; end
      6'd45: begin fmt = FMT_R; sel = 6'h0D; end
      6'd46: begin fmt = FMT_R; sel = 6'h0C; end
      6'd47: begin fmt = FMT_I; sel = 6'h20; end
      6'd48: begin fmt = FMT_I; sel = 6'h24; end
      6'd49: begin fmt = FMT_I; sel = 6'h21; end
      6'd50: begin fmt = FMT_I; sel = 6'h25; end
      6'd51: begin fmt = FMT_I; sel = 6'h23; end
      6'd52: begin fmt = FMT_I; sel = 6'h28; end
      6'd53: begin fmt = FMT_I; sel = 6'h29; end
      6'd54: begin fmt = FMT_I; sel = 6'h2B; end
      6'd55: fmt = FMT_ERET;
      6'd56: fmt = FMT_MFC0;
      6'd57: fmt = FMT_MTC0;
      default: fmt = FMT_ILL;
    endcase
  end

  always_comb begin
    encWord    = 32'h0000_0000;
    encIllegal = 1'b0;
    case (fmt)
      FMT_R:      encWord = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_shamt, sel};
      FMT_I:      encWord = {sel, bus.in_rs, bus.in_rt, bus.in_imm};
      FMT_REGIMM: encWord = {6'h01, bus.in_rs, sel[4:0], bus.in_imm};
      FMT_J:      encWord = {sel, bus.in_target};
      FMT_ERET:   encWord = 32'h4200_0018;
      FMT_MFC0:   encWord = {6'h10, 5'h00, bus.in_rt, bus.in_rd, 11'b0};
      FMT_MTC0:   encWord = {6'h10, 5'h04, bus.in_rt, bus.in_rd, 11'b0};
      FMT_ILL:    encIllegal = 1'b1;
      default:    encWord = 32'h0000_0000;
    endcase
  end

  assign push = bus.in_valid && inReady_q;
  assign pop  = (state_q != EMPTY) && bus.out_ready;

  // In FULL in_ready is low, so a push can only land in EMPTY or ONE
  always_comb begin
    state_d    = state_q;
    headWord_d = headWord_q;
    headIll_d  = headIll_q;
    tailWord_d = tailWord_q;
    tailIll_d  = tailIll_q;
    encCount_d = encCount_q + 16'(pop);
    case (state_q)
      EMPTY: begin
        if (push) begin
          state_d    = ONE;
          headWord_d = encWord;
          headIll_d  = encIllegal;
        end
      end
      ONE: begin
        if (push) begin
          if (pop) begin
            headWord_d = encWord;
            headIll_d  = encIllegal;
          end else begin
            state_d    = FULL;
            tailWord_d = encWord;
            tailIll_d  = encIllegal;
          end
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_d    = ONE;
          headWord_d = tailWord_q;
          headIll_d  = tailIll_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      headWord_q <= 32'h0000_0000;
      headIll_q  <= 1'b0;
      tailWord_q <= 32'h0000_0000;
      tailIll_q  <= 1'b0;
      inReady_q  <= 1'b1;
      encCount_q <= 16'h0000;
    end else begin
      state_q    <= state_d;
      headWord_q <= headWord_d;
      headIll_q  <= headIll_d;
      tailWord_q <= tailWord_d;
      tailIll_q  <= tailIll_d;
      inReady_q  <= (state_d != FULL);
      encCount_q <= encCount_d;
    end
  end

  // Head is masked while empty so a stale word never leaks out
  assign bus.out_valid   = (state_q != EMPTY);
  assign bus.out_word    = bus.out_valid ? headWord_q : 32'h0000_0000;
  assign bus.out_illegal = bus.out_valid && headIll_q;
  assign bus.in_ready    = inReady_q;
  assign bus.enc_count   = encCount_q;

endmodule

// File: tb/tb_ins_encode.sv
// Bench for ins_encode: a queue-based reference model checked every cycle,
// directed literal cases, backpressure, reset and counter-wrap scenarios.
module tb_ins_encode;

  localparam int K_ILL = 0, K_NOP = 1, K_R = 2, K_I = 3, K_RI = 4, K_J = 5,
                 K_ERET = 6, K_MFC0 = 7, K_MTC0 = 8;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;
  int   modelCount;
  logic [32:0] expQ[$];
  int   kindTab[64];
  int   selTab[64];

  ins_encode_if bus ();

  ins_encode dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic buildTables();
    int rCode[28] = '{1,3,5,6,7,9,11,12,13,14,15,18,19,21,23,24,25,26,27,28,39,40,41,42,43,44,45,46};
    int rFun[28]  = '{'h20,'h21,'h22,'h23,'h2A,'h2B,'h1A,'h1B,'h18,'h19,'h24,'h27,'h25,'h26,
                      'h00,'h04,'h03,'h07,'h02,'h06,'h08,'h09,'h10,'h12,'h11,'h13,'h0D,'h0C};
    int iCode[20] = '{2,4,8,10,16,17,20,22,29,30,32,33,47,48,49,50,51,52,53,54};
    int iOp[20]   = '{'h08,'h09,'h0A,'h0B,'h0C,'h0F,'h0D,'h0E,'h04,'h05,'h07,'h06,
                      'h20,'h24,'h21,'h25,'h23,'h28,'h29,'h2B};
    for (int c = 0; c < 64; c++) begin
      kindTab[c] = K_ILL;
      selTab[c]  = 0;
    end
    for (int k = 0; k < 28; k++) begin kindTab[rCode[k]] = K_R; selTab[rCode[k]] = rFun[k]; end
    for (int k = 0; k < 20; k++) begin kindTab[iCode[k]] = K_I; selTab[iCode[k]] = iOp[k]; end
    kindTab[31] = K_RI; selTab[31] = 'h01;
    kindTab[34] = K_RI; selTab[34] = 'h00;
    kindTab[35] = K_RI; selTab[35] = 'h10;
    kindTab[36] = K_RI; selTab[36] = 'h11;
    kindTab[37] = K_J;  selTab[37] = 'h02;
    kindTab[38] = K_J;  selTab[38] = 'h03;
    kindTab[0]  = K_NOP;
    kindTab[55] = K_ERET;
    kindTab[56] = K_MFC0;
    kindTab[57] = K_MTC0;
  endtask

  // Returns {illegal, word} computed from the field layout of each format
  function automatic logic [32:0] encodeModel(input int code, input int rs, input int rt, input int rd,
                                              input int sh, input int imm, input int tgt);
    longint w;
    logic   ill;
    w   = 0;
    ill = 1'b0;
    case (kindTab[code])
      K_R:    w = rs * (1 << 21) + rt * (1 << 16) + rd * (1 << 11) + sh * (1 << 6) + selTab[code];
      K_I:    w = longint'(selTab[code]) * (1 << 26) + rs * (1 << 21) + rt * (1 << 16) + imm;
      K_RI:   w = 1 * (1 << 26) + rs * (1 << 21) + selTab[code] * (1 << 16) + imm;
      K_J:    w = longint'(selTab[code]) * (1 << 26) + tgt;
      K_ERET: w = 'h42000018;
      K_MFC0: w = 16 * (1 << 26) + rt * (1 << 16) + rd * (1 << 11);
      K_MTC0: w = 16 * (1 << 26) + 4 * (1 << 21) + rt * (1 << 16) + rd * (1 << 11);
      K_NOP:  w = 0;
      default: ill = 1'b1;
    endcase
    return {ill, w[31:0]};
  endfunction

  // Reference FIFO: pop the head, then append, so a simultaneous push lands behind it
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      expQ.delete();
      modelCount = 0;
    end else begin
      automatic bit doPush = bus.in_valid && (expQ.size() < 2);
      automatic bit doPop  = (expQ.size() > 0) && bus.out_ready;
      automatic logic [32:0] e = encodeModel(int'(bus.in_inscode), int'(bus.in_rs), int'(bus.in_rt),
                                             int'(bus.in_rd), int'(bus.in_shamt), int'(bus.in_imm),
                                             int'(bus.in_target));
      if (doPop) begin
        void'(expQ.pop_front());
        modelCount++;
      end
      if (doPush) expQ.push_back(e);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      automatic logic [32:0] head = (expQ.size() > 0) ? expQ[0] : 33'h0;
      checkOutput("out_valid", 32'(bus.out_valid), 32'(expQ.size() > 0));
      checkOutput("in_ready", 32'(bus.in_ready), 32'(expQ.size() < 2));
      checkOutput("out_word", bus.out_word, head[31:0]);
      checkOutput("out_illegal", 32'(bus.out_illegal), 32'(head[32]));
      checkOutput("enc_count", 32'(bus.enc_count), 32'(modelCount % 65536));
    end
  end

  task automatic applyStimulus(input int code, input int rs, input int rt, input int rd,
                               input int sh, input int imm, input int tgt);
    @(negedge clk);
    bus.in_valid   = 1'b1;
    bus.in_inscode = 6'(code);
    bus.in_rs      = 5'(rs);
    bus.in_rt      = 5'(rt);
    bus.in_rd      = 5'(rd);
    bus.in_shamt   = 5'(sh);
    bus.in_imm     = 16'(imm);
    bus.in_target  = 26'(tgt);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic randomFields();
    bus.in_inscode = 6'($urandom_range(0, 63));
    bus.in_rs      = 5'($urandom);
    bus.in_rt      = 5'($urandom);
    bus.in_rd      = 5'($urandom);
    bus.in_shamt   = 5'($urandom);
    bus.in_imm     = 16'($urandom);
    bus.in_target  = 26'($urandom);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    modelCount = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_inscode = '0; bus.in_rs = '0; bus.in_rt = '0; bus.in_rd = '0;
    bus.in_shamt = '0; bus.in_imm = '0; bus.in_target = '0;
    buildTables();
    repeat (2) @(negedge clk);
    checkOutput("reset out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("reset out_word", bus.out_word, 32'h0);
    checkOutput("reset enc_count", 32'(bus.enc_count), 32'd0);
    rst = 1'b0;

    bus.out_ready = 1'b1;
    applyStimulus(1, 2, 3, 4, 0, 0, 0);
    checkOutput("ADD valid", 32'(bus.out_valid), 32'd1);
    checkOutput("ADD word", bus.out_word, 32'h00432020);
    applyStimulus(51, 29, 8, 0, 0, 'h0010, 0);
    checkOutput("LW word", bus.out_word, 32'h8FA80010);
    applyStimulus(36, 5, 7, 0, 0, 'hFFFE, 0);
    checkOutput("BGEZAL word", bus.out_word, 32'h04B1FFFE);
    applyStimulus(38, 0, 0, 0, 0, 0, 'h0100000);
    checkOutput("JAL word", bus.out_word, 32'h0C100000);
    applyStimulus(55, 1, 2, 3, 4, 5, 6);
    checkOutput("ERET word", bus.out_word, 32'h42000018);
    checkOutput("ERET illegal", 32'(bus.out_illegal), 32'd0);
    applyStimulus(60, 1, 2, 3, 4, 5, 6);
    checkOutput("code60 word", bus.out_word, 32'h0);
    checkOutput("code60 illegal", 32'(bus.out_illegal), 32'd1);
    applyStimulus(0, 9, 9, 9, 9, 9, 9);
    checkOutput("NOP valid", 32'(bus.out_valid), 32'd1);
    checkOutput("NOP illegal", 32'(bus.out_illegal), 32'd0);
    applyStimulus(56, 0, 12, 14, 0, 0, 0);
    checkOutput("MFC0 word", bus.out_word, 32'h400C7000);

    // Backpressure: two accepted, third held until the consumer drains
    pulseReset();
    bus.out_ready = 1'b0;
    bus.in_rs = '0; bus.in_rt = '0; bus.in_rd = '0; bus.in_shamt = '0;
    @(negedge clk); bus.in_valid = 1'b1; bus.in_inscode = 6'd1;
    @(negedge clk); bus.in_inscode = 6'd3;
    @(negedge clk); bus.in_inscode = 6'd5;
    checkOutput("bp in_ready full", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    checkOutput("bp in_ready held", 32'(bus.in_ready), 32'd0);
    checkOutput("bp head stable", bus.out_word, 32'h00000020);
    bus.out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp second", bus.out_word, 32'h00000021);
    @(negedge clk);
    bus.in_valid = 1'b0;
    checkOutput("bp third", bus.out_word, 32'h00000022);
    @(negedge clk);
    checkOutput("bp enc_count", 32'(bus.enc_count), 32'd3);
    checkOutput("bp drained", 32'(bus.out_valid), 32'd0);

    // Fill the buffer, then assert reset between edges
    bus.out_ready = 1'b0;
    @(negedge clk); bus.in_valid = 1'b1; bus.in_inscode = 6'd7;
    @(negedge clk); bus.in_inscode = 6'd9;
    @(negedge clk); bus.in_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("async rst out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("async rst in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("async rst enc_count", 32'(bus.enc_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.out_ready = ($urandom_range(0, 9) < 7);
      randomFields();
    end

    // Streaming with no backpressure until the transfer counter wraps
    pulseReset();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    begin
      automatic bit reached = 1'b0;
      for (int i = 0; i < 70000 && !reached; i++) begin
        @(negedge clk);
        randomFields();
        if (modelCount == 65536) reached = 1'b1;
      end
      bus.in_valid = 1'b0;
      checkOutput("wrap reached", 32'(reached), 32'd1);
      checkOutput("wrap enc_count", 32'(bus.enc_count), 32'h0000);
    end
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ins_encode.md
INS_ENCODE -- requirements
Module: ins_encode

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  reset; asynchronous, active-high.
REQ-003 in_valid  in  1  request carries an instruction to encode.
REQ-004 in_ready  out  1  encoder can accept a request; transfer on in_valid && in_ready.
REQ-005 in_inscode  in  6  internal instruction code (0..57).
REQ-006 in_rs / in_rt / in_rd / in_shamt  in  5 each  register/shift fields.
REQ-007 in_imm  in  16  immediate/offset.
REQ-008 in_target  in  26  jump target field.
REQ-009 out_valid  out  1  buffer head holds an encoded word.
REQ-010 out_ready  in  1  consumer accepts; transfer on out_valid && out_ready.
REQ-011 out_word  out  32  encoded MIPS32 instruction at buffer head.
REQ-012 out_illegal  out  1  head entry came from an unmapped inscode.
REQ-013 enc_count  out  16  number of completed output transfers.

Function
REQ-014 Encoding SHALL be combinational from in_* and captured into the buffer on input transfer.
REQ-015 R-type (op=00h), word = {op,rs,rt,rd,shamt,funct}; code:funct = 1:20h 3:21h 5:22h 6:23h 7:2Ah 9:2Bh 11:1Ah 12:1Bh 13:18h 14:19h 15:24h 18:27h 19:25h 21:26h 23:00h 24:04h 25:03h 26:07h 27:02h 28:06h 39:08h 40:09h 41:10h 42:12h 43:11h 44:13h 45:0Dh 46:0Ch.
REQ-016 I-type, word = {op,rs,rt,imm}; code:op = 2:08h 4:09h 8:0Ah 10:0Bh 16:0Ch 17:0Fh 20:0Dh 22:0Eh 29:04h 30:05h 32:07h 33:06h 47:20h 48:24h 49:21h 50:25h 51:23h 52:28h 53:29h 54:2Bh.
REQ-017 REGIMM (op=01h), word = {op,rs,RT,imm}, in_rt ignored; code:RT = 31:01h 34:00h 35:10h 36:11h.
REQ-018 J-type, word = {op,target}; 37:op 02h, 38:op 03h.
REQ-019 COP0 (op=10h): 55 ERET = 42000018h fixed; 56 MFC0 = {op,00h,rt,rd,11'b0}; 57 MTC0 = {op,04h,rt,rd,11'b0}.
REQ-020 Code 0 SHALL encode 00000000h (NOP), out_illegal=0.
REQ-021 Any other code SHALL encode 00000000h with out_illegal=1 for that entry.
REQ-022 Buffer: 2-entry FIFO, states EMPTY, ONE, FULL; each entry holds {word, illegal}.
REQ-023 in_ready SHALL be registered: 1 in EMPTY/ONE, 0 in FULL; no combinational path from out_ready.
REQ-024 Transitions: EMPTY+push->ONE; ONE+push only->FULL; ONE+pop only->EMPTY; ONE+push+pop->ONE (new word becomes head next cycle); FULL+pop->ONE; otherwise hold.
REQ-025 Latency: word accepted at edge N appears on out_word with out_valid=1 after edge N, if buffer was EMPTY.
REQ-026 Order SHALL be preserved; out_word/out_illegal SHALL stay stable while out_valid && !out_ready.
REQ-027 out_valid=0 in EMPTY; out_word SHALL then read 00000000h and out_illegal 0.
REQ-028 enc_count increments by 1 per output transfer, wraps FFFFh->0000h; illegal entries count.
REQ-029 in_valid while in_ready=0 SHALL be ignored (no capture, no error).

Reset
REQ-030 rst=1 SHALL immediately force: state EMPTY, out_valid=0, out_word=0, out_illegal=0, in_ready=1, enc_count=0, regardless of clk.
REQ-031 Reset mid-transfer SHALL discard buffered entries; no transfer is counted during rst.

Verification
REQ-032 ADD: code 1, rs=2, rt=3, rd=4, shamt=0 -> out_word 00432020h, out_valid one cycle after accept.
REQ-033 LW 51, rs=29, rt=8, imm=0010h -> 8FA80010h; BGEZAL 36, rs=5, rt=7, imm=FFFEh -> 04B1FFFEh; JAL 38, target=0100000h -> 0C100000h.
REQ-034 ERET 55 -> 42000018h, illegal=0; code 60 -> 00000000h, out_illegal=1; code 0 -> 00000000h, out_illegal=0.
REQ-035 out_ready=0, push codes 1,3,5 back-to-back: first two accepted, in_ready=0 after second, third held; raise out_ready -> words for 1,3,5 in order, enc_count=3.
REQ-036 Continuous in_valid and out_ready=1: one word per cycle, in_ready stays 1; 65536 transfers -> enc_count wraps to 0000h.
REQ-037 FULL buffer, assert rst between edges -> out_valid=0, in_ready=1, enc_count=0 before next edge.
